change_dispenser: RTL and testbench
===================================

// Module: change_dispenser
// PURPOSE
//  Downstream of the vending-machine transaction FSM. Takes the change amount produced at
//  the end of a sale or refund and pays it out one note at a time. Denominations are 50/20/10/5/1,
//  chosen largest-first (greedy). Each note goes to the note hopper over a valid/ack handshake.
//  Reports the remaining balance to the display path and pulses done when the payout completes.
// PARAMETERS
//  WIDTH        8     width of amount/counter datapath (max change 255)
//  GAP_CYCLES   4     idle cycles enforced between consecutive notes (hopper recovery)
//  ACK_TIMEOUT  1000  cycles in ISSUE without note_ack before entering FAULT
// PORTS
//  sys_clk       in   1      system clock, all state on rising edge
//  sys_rst_n     in   1      reset: asynchronous, active-high (1 = reset)
//  start         in   1      one-cycle request to pay out change_amt
//  change_amt    in   WIDTH  amount to dispense, sampled on start
//  note_ack      in   1      hopper accepted current note
//  fault_clr     in   1      operator clear of FAULT; retries current note
//  busy          out  1      1 in any state except IDLE
//  note_valid    out  1      note_code is presented to hopper
//  note_code     out  5      one-hot {50,20,10,5,1}; 0 when note_valid=0
//  remain        out  WIDTH  balance still to dispense
//  notes_issued  out  WIDTH  notes acknowledged in current payout (saturates at 255)
//  done          out  1      one-cycle pulse, payout complete
//  fault         out  1      hopper timeout, held until fault_clr
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high. Reset forces state IDLE and all outputs
//    to 0 immediately. This includes mid-payout; no done pulse is issued for an aborted payout.
//  - States: IDLE, SELECT, ISSUE, GAP, DONE, FAULT. All outputs are registered.
//  - IDLE: start=1 -> remain<=change_amt, notes_issued<=0, go to SELECT.
//    start is ignored in every other state.
//  - SELECT: remain==0 -> DONE. Otherwise latch note_code = largest denomination <= remain,
//    assert note_valid, clear timeout counter, go to ISSUE.
//    Latency: start at edge k -> note_valid=1 after edge k+1.
//  - ISSUE: note_valid and note_code are held stable until note_ack is sampled high.
//    On that edge: remain -= note value, notes_issued += 1, note_valid<=0, note_code<=0,
//    gap counter cleared, go to GAP.
//  - note_ack is ignored outside ISSUE.
//  - ISSUE timeout: the counter reaches ACK_TIMEOUT-1 with no ack -> FAULT, note_valid<=0,
//    fault<=1. An ack on the final timeout cycle wins: no fault.
//  - GAP: wait GAP_CYCLES cycles, then go to SELECT. GAP_CYCLES=0 -> SELECT on the next cycle.
//  - DONE: done=1 for exactly one cycle, then IDLE. remain=0 and notes_issued are held until
//    the next start.
//  - FAULT: remain and notes_issued frozen. fault_clr -> fault<=0, go to SELECT (same note
//    re-selected). Reset also clears FAULT.
//  - Arithmetic: unsigned WIDTH bits. Subtraction never underflows because the denomination
//    is always <= remain.
//  - change_amt=0 with start -> SELECT -> DONE; done is asserted 2 cycles after start and no
//    note is ever valid.
// STRUCTURE
//  - Shared package vm_pkg:
//    - DENOM_50/20/10/5/1 values and one-hot NOTE_* codes (same encoding as the payment-input
//      stage).
//    - Dispenser state encoding (one-hot, 6 bits).
//    - function note_value(code) -> WIDTH-bit value.
//  - Sub-module note_selector: combinational, remain -> one-hot largest denomination
//    <= remain (0 if remain==0). Instantiated once; kept separate so it can be tested
//    exhaustively.
//  - The top level contains the FSM, the remain/notes_issued registers, and the gap and
//    timeout counters.
// TESTING
//  1. start, amt=87, ack 1 cycle after each valid -> codes 50,20,10,5,1,1; remain
//     87,37,17,7,2,1,0; notes_issued=6; one done pulse.
//  2. start, amt=0 -> done=1 exactly 2 cycles after start; note_valid never 1; busy drops
//     after done.
//  3. amt=20, ack withheld 5 cycles -> note_valid/note_code=20 stable throughout; remain
//     stays 20 until the ack edge, then 0.
//  4. amt=5, no ack for ACK_TIMEOUT cycles -> fault=1, note_valid=0, remain=5; fault_clr ->
//     note 5 re-issued; ack -> done.
//  5. amt=255, reset asserted during third note -> all outputs 0 without clock edge; no
//     done; subsequent start works normally.
//  6. amt=255 with start pulses while busy -> start ignored; notes 50x5 then 5; GAP_CYCLES
//     idle cycles between each pair of notes.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: note denominations, one-hot note codes,
// dispenser state encoding and the code-to-value helper.
package vm_pkg;

  localparam int unsigned DENOM_50 = 50;
  localparam int unsigned DENOM_20 = 20;
  localparam int unsigned DENOM_10 = 10;
  localparam int unsigned DENOM_5  = 5;
  localparam int unsigned DENOM_1  = 1;

  // One-hot {50,20,10,5,1}, same encoding as the payment-input stage.
  localparam logic [4:0] NOTE_NONE = 5'b00000;
  localparam logic [4:0] NOTE_50   = 5'b10000;
  localparam logic [4:0] NOTE_20   = 5'b01000;
  localparam logic [4:0] NOTE_10   = 5'b00100;
  localparam logic [4:0] NOTE_5    = 5'b00010;
  localparam logic [4:0] NOTE_1    = 5'b00001;

  typedef enum logic [5:0] {
    StIdle   = 6'b000001,
    StSelect = 6'b000010,
    StIssue  = 6'b000100,
    StGap    = 6'b001000,
    StDone   = 6'b010000,
    StFault  = 6'b100000
  } disp_state_e;

  function automatic logic [7:0] note_value(input logic [4:0] code);
    case (code)
      NOTE_50: return 8'(DENOM_50);
      NOTE_20: return 8'(DENOM_20);
      NOTE_10: return 8'(DENOM_10);
      NOTE_5:  return 8'(DENOM_5);
      NOTE_1:  return 8'(DENOM_1);
      default: return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/note_selector.sv
// Greedy denomination picker: largest note not exceeding the remaining balance,
// or no note when nothing is left.
module note_selector
  import vm_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] remain,
  output logic [4:0]       note_code
);

  logic [31:0] amt;
  assign amt = 32'(remain);

  always_comb begin
    note_code = NOTE_NONE;
    if (amt >= DENOM_50) begin
      note_code = NOTE_50;
    end else if (amt >= DENOM_20) begin
      note_code = NOTE_20;
    end else if (amt >= DENOM_10) begin
      note_code = NOTE_10;
    end else if (amt >= DENOM_5) begin
      note_code = NOTE_5;
    end else if (amt >= DENOM_1) begin
      note_code = NOTE_1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change payout engine: pays a latched amount out one note at a time over a
// valid/ack handshake to the hopper, with inter-note recovery gap and ack timeout.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned ACK_TIMEOUT = 1000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] change_amt,
  input  logic             note_ack,
  input  logic             fault_clr,
  output logic             busy,
  output logic             note_valid,
  output logic [4:0]       note_code,
  output logic [WIDTH-1:0] remain,
  output logic [WIDTH-1:0] notes_issued,
  output logic             done,
  output logic             fault
);

  localparam int unsigned TmoW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  disp_state_e     state_q;
  logic [TmoW-1:0] tmo_cnt_q;
  logic [GapW-1:0] gap_cnt_q;
  logic [4:0]      sel_code;

  note_selector #(
    .WIDTH (WIDTH)
  ) u_note_selector (
    .remain    (remain),
    .note_code (sel_code)
  );

  // sys_rst_n is active-high despite its name.
  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      state_q      <= StIdle;
      tmo_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      busy         <= 1'b0;
      note_valid   <= 1'b0;
      note_code    <= NOTE_NONE;
      remain       <= '0;
      notes_issued <= '0;
      done         <= 1'b0;
      fault        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            remain       <= change_amt;
            notes_issued <= '0;
            busy         <= 1'b1;
            state_q      <= StSelect;
          end
        end

        StSelect: begin
          if (remain == '0) begin
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            note_code  <= sel_code;
            note_valid <= 1'b1;
            tmo_cnt_q  <= '0;
            state_q    <= StIssue;
          end
        end

        StIssue: begin
          // An ack on the final timeout cycle takes priority over the fault.
          if (note_ack) begin
            remain <= remain - WIDTH'(note_value(note_code));
            if (notes_issued != '1) begin
              notes_issued <= notes_issued + WIDTH'(1);
            end
            note_valid <= 1'b0;
            note_code  <= NOTE_NONE;
            gap_cnt_q  <= '0;
            state_q    <= StGap;
          end else if (32'(tmo_cnt_q) == ACK_TIMEOUT - 1) begin
            note_valid <= 1'b0;
            note_code  <= NOTE_NONE;
            fault      <= 1'b1;
            state_q    <= StFault;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
          end
        end

        StGap: begin
          // GAP occupies GAP_CYCLES cycles, minimum one.
          if (32'(gap_cnt_q) + 32'd1 >= GAP_CYCLES) begin
            state_q <= StSelect;
          end else begin
            gap_cnt_q <= gap_cnt_q + GapW'(1);
          end
        end

        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end

        StFault: begin
          if (fault_clr) begin
            fault   <= 1'b0;
            state_q <= StSelect;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  note_code_idle_a : assert property (@(posedge sys_clk) disable iff (sys_rst_n)
    !note_valid |-> note_code == NOTE_NONE);
  note_code_onehot_a : assert property (@(posedge sys_clk) disable iff (sys_rst_n)
    note_valid |-> $onehot(note_code));

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: greedy payout sequences, zero amount,
// held ack, timeout/fault recovery, asynchronous reset abort and start masking.
module tb_change_dispenser;
  import vm_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned GAP   = 4;
  localparam int unsigned TMO   = 1000;

  logic             sys_clk    = 1'b0;
  logic             sys_rst_n  = 1'b1;
  logic             start      = 1'b0;
  logic [WIDTH-1:0] change_amt = '0;
  logic             note_ack   = 1'b0;
  logic             fault_clr  = 1'b0;
  logic             busy;
  logic             note_valid;
  logic [4:0]       note_code;
  logic [WIDTH-1:0] remain;
  logic [WIDTH-1:0] notes_issued;
  logic             done;
  logic             fault;

  int n_vec = 0;
  int n_err = 0;
  int idle_cnt;
  int pulses;

  logic [4:0] codes87 [6] = '{NOTE_50, NOTE_20, NOTE_10, NOTE_5, NOTE_1, NOTE_1};
  int         rem87   [7] = '{87, 37, 17, 7, 2, 1, 0};
  logic [4:0] codes255[6] = '{NOTE_50, NOTE_50, NOTE_50, NOTE_50, NOTE_50, NOTE_5};
  int         rem255  [7] = '{255, 205, 155, 105, 55, 5, 0};

  always #5 sys_clk = ~sys_clk;

  change_dispenser #(
    .WIDTH       (WIDTH),
    .GAP_CYCLES  (GAP),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .start        (start),
    .change_amt   (change_amt),
    .note_ack     (note_ack),
    .fault_clr    (fault_clr),
    .busy         (busy),
    .note_valid   (note_valid),
    .note_code    (note_code),
    .remain       (remain),
    .notes_issued (notes_issued),
    .done         (done),
    .fault        (fault)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; counts negedges with note_valid low until it rises.
  task automatic wait_valid(input string tag);
    idle_cnt = 0;
    while (!note_valid && idle_cnt < 50) begin
      idle_cnt++;
      @(negedge sys_clk);
    end
    check_val({tag, "_valid"}, 32'(note_valid), 32'd1);
  endtask

  task automatic ack_note(input int delay, input logic [4:0] code);
    for (int i = 0; i < delay; i++) begin
      @(negedge sys_clk);
      check_val("hold_valid", 32'(note_valid), 32'd1);
      check_val("hold_code", 32'(note_code), 32'(code));
    end
    note_ack = 1'b1;
    @(negedge sys_clk);
    note_ack = 1'b0;
  endtask

  task automatic count_done(input int window);
    pulses = 0;
    for (int i = 0; i < window; i++) begin
      if (done) pulses++;
      @(negedge sys_clk);
    end
  endtask

  task automatic kick(input int amt);
    change_amt = WIDTH'(amt);
    start      = 1'b1;
    @(negedge sys_clk);
    start      = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge sys_clk);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_valid", 32'(note_valid), 32'd0);
    check_val("rst_remain", 32'(remain), 32'd0);
    check_val("rst_fault", 32'(fault), 32'd0);
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);

    // 1: amount 87, ack one cycle after each valid
    kick(87);
    check_val("t1_remain0", 32'(remain), 32'd87);
    check_val("t1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 6; i++) begin
      wait_valid("t1");
      if (i == 0) check_val("t1_latency", 32'(idle_cnt), 32'd1);
      check_val("t1_code", 32'(note_code), 32'(codes87[i]));
      check_val("t1_rem_before", 32'(remain), 32'(rem87[i]));
      ack_note(1, codes87[i]);
      check_val("t1_rem_after", 32'(remain), 32'(rem87[i+1]));
      check_val("t1_issued", 32'(notes_issued), 32'(i + 1));
      check_val("t1_valid_low", 32'(note_valid), 32'd0);
    end
    count_done(20);
    check_val("t1_done_pulses", 32'(pulses), 32'd1);
    check_val("t1_final_issued", 32'(notes_issued), 32'd6);
    check_val("t1_final_remain", 32'(remain), 32'd0);
    check_val("t1_idle_busy", 32'(busy), 32'd0);

    // 2: zero amount completes with no note
    kick(0);
    check_val("t2_done_k", 32'(done), 32'd0);
    check_val("t2_busy", 32'(busy), 32'd1);
    check_val("t2_valid_k", 32'(note_valid), 32'd0);
    @(negedge sys_clk);
    check_val("t2_done_k1", 32'(done), 32'd1);
    check_val("t2_valid_k1", 32'(note_valid), 32'd0);
    @(negedge sys_clk);
    check_val("t2_done_off", 32'(done), 32'd0);
    check_val("t2_busy_off", 32'(busy), 32'd0);
    check_val("t2_issued", 32'(notes_issued), 32'd0);

    // 3: amount 20, ack withheld five cycles
    kick(20);
    wait_valid("t3");
    check_val("t3_code", 32'(note_code), 32'(NOTE_20));
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      check_val("t3_hold_valid", 32'(note_valid), 32'd1);
      check_val("t3_hold_code", 32'(note_code), 32'(NOTE_20));
      check_val("t3_hold_remain", 32'(remain), 32'd20);
    end
    ack_note(0, NOTE_20);
    check_val("t3_remain", 32'(remain), 32'd0);
    count_done(15);
    check_val("t3_done_pulses", 32'(pulses), 32'd1);

    // 4: amount 5, hopper timeout then operator clear
    kick(5);
    wait_valid("t4");
    repeat (TMO - 1) @(negedge sys_clk);
    check_val("t4_pre_fault", 32'(fault), 32'd0);
    check_val("t4_pre_valid", 32'(note_valid), 32'd1);
    @(negedge sys_clk);
    check_val("t4_fault", 32'(fault), 32'd1);
    check_val("t4_valid", 32'(note_valid), 32'd0);
    check_val("t4_code", 32'(note_code), 32'd0);
    check_val("t4_remain", 32'(remain), 32'd5);
    note_ack = 1'b1;
    repeat (3) @(negedge sys_clk);
    note_ack = 1'b0;
    check_val("t4_fault_held", 32'(fault), 32'd1);
    check_val("t4_remain_held", 32'(remain), 32'd5);
    check_val("t4_issued_held", 32'(notes_issued), 32'd0);
    fault_clr = 1'b1;
    @(negedge sys_clk);
    fault_clr = 1'b0;
    check_val("t4_fault_clr", 32'(fault), 32'd0);
    wait_valid("t4_retry");
    check_val("t4_retry_code", 32'(note_code), 32'(NOTE_5));
    ack_note(0, NOTE_5);
    count_done(15);
    check_val("t4_done_pulses", 32'(pulses), 32'd1);
    check_val("t4_issued", 32'(notes_issued), 32'd1);

    // 4b: ack on the last timeout cycle beats the fault
    kick(1);
    wait_valid("t4b");
    repeat (TMO - 1) @(negedge sys_clk);
    ack_note(0, NOTE_1);
    check_val("t4b_fault", 32'(fault), 32'd0);
    check_val("t4b_remain", 32'(remain), 32'd0);
    count_done(15);
    check_val("t4b_done_pulses", 32'(pulses), 32'd1);

    // 5: asynchronous reset during the third note
    kick(255);
    for (int i = 0; i < 2; i++) begin
      wait_valid("t5");
      ack_note(1, codes255[i]);
    end
    wait_valid("t5_third");
    check_val("t5_rem_third", 32'(remain), 32'd155);
    #2 sys_rst_n = 1'b1;
    #1;
    check_val("t5_busy", 32'(busy), 32'd0);
    check_val("t5_valid", 32'(note_valid), 32'd0);
    check_val("t5_code", 32'(note_code), 32'd0);
    check_val("t5_remain", 32'(remain), 32'd0);
    check_val("t5_issued", 32'(notes_issued), 32'd0);
    check_val("t5_fault", 32'(fault), 32'd0);
    @(negedge sys_clk);
    count_done(3);
    sys_rst_n = 1'b0;
    count_done(10);
    check_val("t5_no_done", 32'(pulses), 32'd0);
    check_val("t5_idle", 32'(busy), 32'd0);
    kick(6);
    wait_valid("t5_after");
    check_val("t5_after_code5", 32'(note_code), 32'(NOTE_5));
    ack_note(0, NOTE_5);
    wait_valid("t5_after2");
    check_val("t5_after_code1", 32'(note_code), 32'(NOTE_1));
    ack_note(0, NOTE_1);
    count_done(15);
    check_val("t5_after_done", 32'(pulses), 32'd1);
    check_val("t5_after_issued", 32'(notes_issued), 32'd2);

    // 6: amount 255, start and stray acks ignored while busy; spacing between notes
    kick(255);
    for (int i = 0; i < 6; i++) begin
      wait_valid("t6");
      // GAP cycles plus the SELECT cycle, plus the stray-ack negedge already consumed
      if (i > 0) check_val("t6_gap", 32'(idle_cnt + 1), 32'(GAP + 1));
      check_val("t6_code", 32'(note_code), 32'(codes255[i]));
      check_val("t6_rem_before", 32'(remain), 32'(rem255[i]));
      kick(9);
      check_val("t6_start_ignored", 32'(remain), 32'(rem255[i]));
      ack_note(0, codes255[i]);
      check_val("t6_rem_after", 32'(remain), 32'(rem255[i+1]));
      note_ack = 1'b1;
      @(negedge sys_clk);
      note_ack = 1'b0;
      check_val("t6_stray_ack", 32'(remain), 32'(rem255[i+1]));
      if (i == 5) begin
        count_done(15);
        check_val("t6_done_pulses", 32'(pulses), 32'd1);
        check_val("t6_issued", 32'(notes_issued), 32'd6);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
